arbitro_mux2x1: RTL and testbench



---
 rtl/arbitro_mux2x1_pkg.sv | 19 +
 rtl/arbitro_mux2x1_mux.sv | 22 ++
 rtl/arbitro_mux2x1.sv | 157 +++++++++++++++
 tb/tb_arbitro_mux2x1.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_mux2x1_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_pkg
// Shared types and constants for the arbitro_mux2x1 round-robin arbiter.
//   state_t : arbiter FSM encoding (IDLE, GRANT_A, GRANT_B)
//   SEL_A   : mux select / requester id for A
//   SEL_B   : mux select / requester id for B
// ---------------------------------------------------------------------------
package arbitro_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arbitro_mux2x1_mux.sv
// ---------------------------------------------------------------------------
// mux2x1_w
// WIDTH-bit combinational 2:1 multiplexer feeding the arbiter output register.
//   i_sel : select, SEL_A picks i_a, SEL_B picks i_b
//   i_a   : data input A
//   i_b   : data input B
//   o_y   : selected data
// ---------------------------------------------------------------------------
module mux2x1_w
   import arbitro_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = (i_sel == SEL_B) ? i_b : i_a;

endmodule

// File: rtl/arbitro_mux2x1.sv
// ---------------------------------------------------------------------------
// arbitro_mux2x1
// Two-requester round-robin arbiter owning the select of a 2:1 mux and a
// registered WIDTH-bit output channel.
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   req_a/b    : level-sensitive requests
//   din_a/b    : requester data
//   gnt_a/b    : registered grants (decoded from the state flop)
//   sel        : mux select, 0 = A, 1 = B
//   dout       : registered mux output
//   dout_valid : dout captured from a granted, requesting source last edge
// Optional feature: define ARBITRO_HOLD_LIMIT_EN to force a grant hand-off
// after MAX_HOLD consecutive granted cycles when the other side requests.
// ---------------------------------------------------------------------------
module arbitro_mux2x1
   import arbitro_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid
);

   if (MAX_HOLD < 1) begin : g_max_hold_chk
      $error("MAX_HOLD must be at least 1");
   end

   state_t           r_state;
   state_t           w_state_next;
   logic             r_last;
   logic             w_hold_reached;
   logic             w_capture;
   logic [WIDTH-1:0] w_mux_y;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;

`ifdef ARBITRO_HOLD_LIMIT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] r_hold_cnt;

   // Counter holds the number of already-completed cycles in this grant, so
   // the current cycle is the MAX_HOLD-th one once it reaches MAX_HOLD-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_hold_cnt <= '0;
      end else if ((r_state != IDLE) && (r_hold_cnt != HOLD_MAX)) begin
         r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   assign w_hold_reached = (r_hold_cnt >= HOLD_LAST);
`else
   assign w_hold_reached = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Round-robin priority: remembers who entered a grant most recently
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= SEL_B;
      end else if (w_state_next == GRANT_A) begin
         r_last <= SEL_A;
      end else if (w_state_next == GRANT_B) begin
         r_last <= SEL_B;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (req_a && req_b) begin
               w_state_next = (r_last == SEL_B) ? GRANT_A : GRANT_B;
            end else if (req_a) begin
               w_state_next = GRANT_A;
            end else if (req_b) begin
               w_state_next = GRANT_B;
            end
         end
         GRANT_A: begin
            if (!req_a) begin
               w_state_next = req_b ? GRANT_B : IDLE;
            end else if (w_hold_reached && req_b) begin
               w_state_next = GRANT_B;
            end
         end
         GRANT_B: begin
            if (!req_b) begin
               w_state_next = req_a ? GRANT_A : IDLE;
            end else if (w_hold_reached && req_a) begin
               w_state_next = GRANT_A;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Output decode, flops only
   always_comb begin
      gnt_a = (r_state == GRANT_A);
      gnt_b = (r_state == GRANT_B);
      sel   = (r_state == GRANT_B) ? SEL_B : SEL_A;
   end

   assign w_capture = ((r_state == GRANT_A) && req_a) ||
                      ((r_state == GRANT_B) && req_b);

   mux2x1_w #(
      .WIDTH (WIDTH)
   ) u_mux (
      .i_sel (sel),
      .i_a   (din_a),
      .i_b   (din_b),
      .o_y   (w_mux_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else if (w_capture) begin
         r_dout       <= w_mux_y;
         r_dout_valid <= 1'b1;
      end else begin
         r_dout_valid <= 1'b0;
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_arbitro_mux2x1.sv
// ---------------------------------------------------------------------------
// tb_arbitro_mux2x1
// Directed self-checking bench for arbitro_mux2x1 (WIDTH=8, MAX_HOLD=4).
// Observed vector w_obs = {gnt_a, gnt_b, sel, dout_valid, dout[7:0]}.
// Build with ARBITRO_HOLD_LIMIT_EN defined to exercise the hold limit.
// ---------------------------------------------------------------------------
module tb_arbitro_mux2x1;

   logic       clk;
   logic       rst;
   logic       req_a;
   logic       req_b;
   logic [7:0] din_a;
   logic [7:0] din_b;
   logic       gnt_a;
   logic       gnt_b;
   logic       sel;
   logic [7:0] dout;
   logic       dout_valid;

   logic [11:0] w_obs;
   int checks   = 0;
   int failures = 0;

   assign w_obs = {gnt_a, gnt_b, sel, dout_valid, dout};

   arbitro_mux2x1 #(
      .WIDTH    (8),
      .MAX_HOLD (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_a      (req_a),
      .req_b      (req_b),
      .din_a      (din_a),
      .din_b      (din_b),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req_a = 1'b1; req_b = 1'b1; din_a = 8'hFF; din_b = 8'hEE;
      tick();
      tick();
      checks++;
      if (w_obs !== 12'h000) begin
         failures++;
         $display("FAIL reset_state: got %h want %h", w_obs, 12'h000);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (w_obs !== 12'h800) begin
         failures++;
         $display("FAIL reset_release_tie: got %h want %h", w_obs, 12'h800);
      end
      go_idle();
      checks++;
      if (w_obs !== 12'h000) begin
         failures++;
         $display("FAIL reset_back_idle: got %h want %h", w_obs, 12'h000);
      end
   endtask

   task automatic test_single();
      req_a = 1'b1; din_a = 8'hA5;
      tick();
      checks++;
      if (w_obs !== 12'h800) begin
         failures++;
         $display("FAIL single_grant: got %h want %h", w_obs, 12'h800);
      end
      tick();
      checks++;
      if (w_obs !== 12'h9A5) begin
         failures++;
         $display("FAIL single_data: got %h want %h", w_obs, 12'h9A5);
      end
      req_a = 1'b0;
      tick();
      checks++;
      if (w_obs !== 12'h0A5) begin
         failures++;
         $display("FAIL single_release: got %h want %h", w_obs, 12'h0A5);
      end
   endtask

   task automatic test_round_robin();
      logic [11:0] exp_tab [8];
      exp_tab = '{12'h6A5, 12'h7B1, 12'h8B1, 12'h911,
                  12'h611, 12'h722, 12'h822, 12'h022};
      for (int unsigned i = 0; i < 8; i++) begin
         case (i)
            0: begin req_b = 1'b1; din_b = 8'hB1; end
            1: begin req_a = 1'b1; din_a = 8'h11; end
            2: req_b = 1'b0;
            3: begin req_b = 1'b1; din_b = 8'h22; end
            4: req_a = 1'b0;
            5: begin req_a = 1'b1; din_a = 8'h33; end
            6: req_b = 1'b0;
            default: req_a = 1'b0;
         endcase
         tick();
         checks++;
         if (w_obs !== exp_tab[i]) begin
            failures++;
            $display("FAIL round_robin[%0d]: got %h want %h", i, w_obs, exp_tab[i]);
         end
      end
   endtask

   task automatic test_tie_after_b();
      req_b = 1'b1;
      tick();
      checks++;
      if (w_obs !== 12'h622) begin
         failures++;
         $display("FAIL tie_b_grant: got %h want %h", w_obs, 12'h622);
      end
      req_b = 1'b0;
      tick();
      checks++;
      if (w_obs !== 12'h022) begin
         failures++;
         $display("FAIL tie_b_release: got %h want %h", w_obs, 12'h022);
      end
      req_a = 1'b1; req_b = 1'b1; din_a = 8'h44; din_b = 8'h55;
      tick();
      checks++;
      if (w_obs !== 12'h822) begin
         failures++;
         $display("FAIL tie_a_wins: got %h want %h", w_obs, 12'h822);
      end
      go_idle();
      checks++;
      if (w_obs !== 12'h022) begin
         failures++;
         $display("FAIL tie_idle: got %h want %h", w_obs, 12'h022);
      end
      req_a = 1'b1; req_b = 1'b1;
      tick();
      checks++;
      if (w_obs !== 12'h622) begin
         failures++;
         $display("FAIL tie_b_wins: got %h want %h", w_obs, 12'h622);
      end
      go_idle();
   endtask

   task automatic test_hold_limit();
      req_a = 1'b1; din_a = 8'h3C;
      tick();
      checks++;
      if (w_obs !== 12'h822) begin
         failures++;
         $display("FAIL hold_first_grant: got %h want %h", w_obs, 12'h822);
      end
      req_b = 1'b1; din_b = 8'hC3;
`ifdef ARBITRO_HOLD_LIMIT_EN
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (w_obs !== 12'h93C) begin
            failures++;
            $display("FAIL hold_keep_a[%0d]: got %h want %h", i, w_obs, 12'h93C);
         end
      end
      tick();
      checks++;
      if (w_obs !== 12'h73C) begin
         failures++;
         $display("FAIL hold_handoff: got %h want %h", w_obs, 12'h73C);
      end
      tick();
      checks++;
      if (w_obs !== 12'h7C3) begin
         failures++;
         $display("FAIL hold_b_data: got %h want %h", w_obs, 12'h7C3);
      end
      go_idle();
      // Saturation: A alone well past MAX_HOLD, then B must win next edge
      req_a = 1'b1;
      tick();
      checks++;
      if (w_obs !== 12'h8C3) begin
         failures++;
         $display("FAIL sat_grant: got %h want %h", w_obs, 12'h8C3);
      end
      for (int unsigned i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (w_obs !== 12'h93C) begin
            failures++;
            $display("FAIL sat_keep_a[%0d]: got %h want %h", i, w_obs, 12'h93C);
         end
      end
      req_b = 1'b1;
      tick();
      checks++;
      if (w_obs !== 12'h73C) begin
         failures++;
         $display("FAIL sat_handoff: got %h want %h", w_obs, 12'h73C);
      end
`else
      for (int unsigned i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (w_obs !== 12'h93C) begin
            failures++;
            $display("FAIL nohold_keep_a[%0d]: got %h want %h", i, w_obs, 12'h93C);
         end
      end
`endif
      go_idle();
   endtask

   task automatic test_reset_mid_grant();
      req_b = 1'b1; din_b = 8'h5A;
      tick();
      checks++;
      if (w_obs[11:8] !== 4'h6) begin
         failures++;
         $display("FAIL mid_pre_grant: got %h want %h", w_obs[11:8], 4'h6);
      end
      tick();
      checks++;
      if (w_obs !== 12'h75A) begin
         failures++;
         $display("FAIL mid_pre_data: got %h want %h", w_obs, 12'h75A);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (w_obs !== 12'h000) begin
         failures++;
         $display("FAIL mid_reset: got %h want %h", w_obs, 12'h000);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (w_obs !== 12'h600) begin
         failures++;
         $display("FAIL mid_after_reset: got %h want %h", w_obs, 12'h600);
      end
      go_idle();
   endtask

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; din_a = '0; din_b = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_tie_after_b();
      test_hold_limit();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
